// File: rtl/ddr_multi_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : ddr_multi_port_arb
// Brief    : N-channel DDR instruction arbiter with in-order read-beat routing
// Revision : 1.0 - initial release
// ============================================================================
module ddr_multi_port_arb #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int BL_W      = 4,
    parameter int TAG_DEPTH = 16,
    parameter int ARB_MODE  = 0
) (
    input  logic                     sys_clk_200M,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH-1:0]        ch_rd_req,
    input  logic [NUM_CH-1:0]        ch_wr_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*BL_W-1:0]   ch_bl_size,
    input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
    output logic [NUM_CH-1:0]        ch_op_ack,
    output logic                     ddr_ins_op_vld,
    output logic                     ddr_rd_req,
    output logic                     ddr_wr_req,
    output logic [ADDR_W-1:0]        ddr_address,
    output logic [BL_W-1:0]          ddr_bl_size,
    output logic [DATA_W-1:0]        ddr_write_data,
    input  logic                     ddr_ins_push_vld,
    input  logic                     ddr_rd_data_vld,
    input  logic [DATA_W-1:0]        ddr_rd_data,
    output logic [NUM_CH-1:0]        ch_rd_data_vld,
    output logic [DATA_W-1:0]        ch_rd_data,
    output logic                     rd_orphan_err,
    output logic                     tag_full
);

    localparam int c_ch_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_tag_aw = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int c_cnt_w  = c_tag_aw + 1;
    localparam int c_tag_w  = c_ch_w + BL_W;

    localparam logic [c_ch_w-1:0]  c_last_ch  = c_ch_w'(NUM_CH - 1);
    localparam logic [BL_W-1:0]    c_bl_one   = BL_W'(1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(TAG_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_grant_en;
    logic   w_push_en;

    // ------------------------------------------------------------------
    // Per-channel views of the packed request buses
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr  [NUM_CH];
    logic [BL_W-1:0]   w_bl    [NUM_CH];
    logic [DATA_W-1:0] w_wdata [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign w_addr[gi]  = ch_address[gi*ADDR_W +: ADDR_W];
        assign w_bl[gi]    = ch_bl_size[gi*BL_W +: BL_W];
        assign w_wdata[gi] = ch_write_data[gi*DATA_W +: DATA_W];
    end

    logic [c_ch_w-1:0]  r_gnt;
    logic [c_ch_w-1:0]  r_rr_ptr;
    logic [NUM_CH-1:0]  w_elig;
    logic               w_gnt_found;
    logic [c_ch_w-1:0]  w_gnt_idx;
    logic               w_gnt_rd;
    logic [BL_W-1:0]    w_rd_bl;

    // A channel whose ack is on the wire this cycle still shows its request;
    // it must not be granted a second time.
    assign w_elig = (ch_rd_req | ch_wr_req) & ~ch_op_ack
                  & ~(ch_rd_req & {NUM_CH{tag_full}});

    always_comb begin : p_grant
        logic [c_ch_w-1:0] cand;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        cand        = (ARB_MODE == 1) ? '0 : r_rr_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_gnt_found && w_elig[cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = cand;
            end
            cand = (cand == c_last_ch) ? '0 : cand + 1'b1;
        end
    end

    assign w_gnt_rd = ch_rd_req[w_gnt_idx];
    assign w_rd_bl  = (w_bl[w_gnt_idx] == '0) ? c_bl_one : w_bl[w_gnt_idx];

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk_200M) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_push_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_found) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ddr_ins_push_vld) begin
                    w_push_en   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_200M) begin
        if (!sys_rst_n) begin
            ddr_ins_op_vld <= 1'b0;
            ddr_rd_req     <= 1'b0;
            ddr_wr_req     <= 1'b0;
            ddr_address    <= '0;
            ddr_bl_size    <= '0;
            ddr_write_data <= '0;
            ch_op_ack      <= '0;
            r_gnt          <= '0;
            r_rr_ptr       <= '0;
        end else begin
            ch_op_ack <= '0;
            if (w_grant_en) begin
                ddr_ins_op_vld <= 1'b1;
                ddr_rd_req     <= w_gnt_rd;
                ddr_wr_req     <= ~w_gnt_rd;
                ddr_address    <= w_addr[w_gnt_idx];
                ddr_bl_size    <= w_gnt_rd ? w_rd_bl : c_bl_one;
                ddr_write_data <= w_wdata[w_gnt_idx];
                r_gnt          <= w_gnt_idx;
            end else if (w_push_en) begin
                ddr_ins_op_vld   <= 1'b0;
                ddr_rd_req       <= 1'b0;
                ddr_wr_req       <= 1'b0;
                ch_op_ack[r_gnt] <= 1'b1;
                r_rr_ptr         <= (r_gnt == c_last_ch) ? '0 : r_gnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read tag FIFO and read-beat routing
    // ------------------------------------------------------------------
    logic [c_tag_w-1:0]  r_tag_mem [TAG_DEPTH];
    logic [c_tag_aw-1:0] r_wr_ptr;
    logic [c_tag_aw-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_tag_cnt;
    logic [BL_W-1:0]     r_beat_cnt;

    logic [c_tag_w-1:0]  w_head;
    logic [c_ch_w-1:0]   w_head_ch;
    logic [BL_W-1:0]     w_head_beats;
    logic                w_tag_empty;
    logic                w_tag_push;
    logic                w_tag_pop;
    logic                w_last_beat;

    assign w_head       = r_tag_mem[r_rd_ptr];
    assign w_head_ch    = w_head[c_tag_w-1:BL_W];
    assign w_head_beats = w_head[BL_W-1:0];
    assign w_tag_empty  = (r_tag_cnt == '0);
    assign w_tag_push   = w_push_en & ddr_rd_req;
    assign w_last_beat  = (({1'b0, r_beat_cnt} + 1'b1) == {1'b0, w_head_beats});
    assign w_tag_pop    = ddr_rd_data_vld & ~w_tag_empty & w_last_beat;
    assign tag_full     = (r_tag_cnt == c_full_cnt);

    always_ff @(posedge sys_clk_200M) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                r_tag_mem[i] <= '0;
            end
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_tag_cnt      <= '0;
            r_beat_cnt     <= '0;
            ch_rd_data_vld <= '0;
            ch_rd_data     <= '0;
            rd_orphan_err  <= 1'b0;
        end else begin
            ch_rd_data_vld <= '0;
            if (w_tag_push) begin
                r_tag_mem[r_wr_ptr] <= {r_gnt, ddr_bl_size};
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (ddr_rd_data_vld) begin
                if (w_tag_empty) begin
                    rd_orphan_err <= 1'b1;
                end else begin
                    ch_rd_data_vld[w_head_ch] <= 1'b1;
                    ch_rd_data                <= ddr_rd_data;
                    if (w_last_beat) begin
                        r_beat_cnt <= '0;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
            end
            case ({w_tag_push, w_tag_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ddr_multi_port_arb.md
DDR_MULTI_PORT_ARB -- requirements
Module: ddr_multi_port_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 28, DDR instruction address width.
REQ-003 SHALL have parameter DATA_W, default 128, DDR data width.
REQ-004 SHALL have parameter BL_W, default 4, burst-length field width.
REQ-005 SHALL have parameter TAG_DEPTH, default 16, outstanding-read tag FIFO depth (power of 2).
REQ-006 SHALL have parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority with ch0 highest.
REQ-007 SHALL have ports sys_clk_200M in 1, the single clock, and sys_rst_n in 1, reset; one clock, reset synchronous and active-low.
REQ-008 SHALL have ports ch_rd_req in NUM_CH and ch_wr_req in NUM_CH, per-channel request levels held until ack.
REQ-009 SHALL have ports ch_address in NUM_CH*ADDR_W, ch_bl_size in NUM_CH*BL_W and ch_write_data in NUM_CH*DATA_W, packed per channel with ch0 in the LSBs.
REQ-010 SHALL have port ch_op_ack out NUM_CH, one-cycle accept pulse per channel.
REQ-011 SHALL have ports ddr_ins_op_vld out 1, ddr_rd_req out 1, ddr_wr_req out 1, ddr_address out ADDR_W, ddr_bl_size out BL_W and ddr_write_data out DATA_W, the downstream instruction.
REQ-012 SHALL have port ddr_ins_push_vld in 1, a downstream accept pulse.
REQ-013 SHALL have ports ddr_rd_data_vld in 1 and ddr_rd_data in DATA_W, returned read beats in issue order.
REQ-014 SHALL have ports ch_rd_data_vld out NUM_CH and ch_rd_data out DATA_W, routed read beats.
REQ-015 SHALL have ports rd_orphan_err out 1 (sticky) and tag_full out 1.

Function
REQ-016 SHALL run FSM IDLE -> ISSUE -> IDLE; IDLE grants one eligible channel per cycle, and ISSUE holds the instruction until push.
REQ-017 SHALL treat a channel as eligible when rd or wr is high and no ack is pending; a read-eligible channel is masked while tag_full=1, and writes stay eligible.
REQ-018 SHALL treat rd+wr both high on a channel as a read, with wr ignored.
REQ-019 SHALL, in round-robin mode, search from (last granted + 1) mod NUM_CH; in fixed mode, select the lowest index.
REQ-020 SHALL register the grant in IDLE cycle N and assert ddr_ins_op_vld with latched fields from cycle N+1.
REQ-021 SHALL hold all ddr_* instruction outputs stable while in ISSUE until the cycle ddr_ins_push_vld=1.
REQ-022 SHALL, on push, assert ch_op_ack[g] the next cycle, deassert ddr_ins_op_vld the next cycle and return to IDLE; re-grant is possible in that same cycle.
REQ-023 SHALL force ddr_bl_size=1 on writes, and SHALL issue read bl_size=0 as 1.
REQ-024 SHALL push tag {channel, beats} into the tag FIFO on each read push.
REQ-025 SHALL register each ddr_rd_data_vld beat: ch_rd_data_vld[head.channel] and ch_rd_data assert 1 cycle later.
REQ-026 SHALL decrement a beat counter per beat and pop the tag on the last beat; push and pop in the same cycle are both performed, and the count is unchanged.
REQ-027 SHALL drop a beat that arrives with the tag FIFO empty, emit no ch_rd_data_vld, and set rd_orphan_err until reset.
REQ-028 SHALL assert tag_full when the count equals TAG_DEPTH, and SHALL update the round-robin pointer only on push.
REQ-029 SHALL ignore ddr_ins_push_vld while in IDLE.

Reset
REQ-030 SHALL, on sys_rst_n=0 at a clock edge, go to IDLE and zero all outputs, the tag FIFO, the counters and the round-robin pointer (to ch0), including mid-ISSUE or mid-burst; in-flight tags are discarded.

Verification
REQ-031 SHALL cover round-robin fairness: ch0..3 rd high, push every ISSUE -> grant order 0,1,2,3,0; op_vld rises 1 cycle after grant.
REQ-032 SHALL cover backpressure: ch2 write with addr 0x100, push delayed 5 cycles -> outputs stable for 5 cycles, then ch_op_ack[2] pulses once and bl_size=1.
REQ-033 SHALL cover read routing: ch1 read bl=4, ch3 read bl=2 issued; 6 beats returned -> 4 beats on ch1 then 2 on ch3, each 1 cycle late; tag FIFO empty afterwards.
REQ-034 SHALL cover a full tag FIFO: 16 reads outstanding -> tag_full=1, a ch0 read is not granted while a ch1 write is; the first pop re-enables the read.
REQ-035 SHALL cover an orphan beat: ddr_rd_data_vld with no tags -> no ch_rd_data_vld and rd_orphan_err=1 stays high.
REQ-036 SHALL cover reset mid-burst: after 2 of 4 beats, sys_rst_n=0 for 1 cycle -> all outputs 0, tags cleared, and a following beat is counted as an orphan.
